// File: rtl/alu_seq.sv
// Handshaked, parametrised ALU: registered operands in, registered result plus flags out.
// Define ALU_SEQ_MUL_EN to build the iterative WIDTH-cycle multiplier behind opcode 16.
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_hi,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flag_ill
);

   localparam int MSB = WIDTH - 1;
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef ALU_SEQ_MUL_EN
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

   state_t state, next_state, accept_target;
   logic accept;
   logic is_mul;

   logic [WIDTH-1:0] alu_res;
   logic [WIDTH:0]   sum_ext;
   logic             alu_c, alu_v, alu_ill;

   assign accept = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

   logic [WIDTH-1:0]   mcand, prod_hi, prod_lo;
   logic [SHW-1:0]     step_cnt;
   logic [WIDTH:0]     add_hi;
   logic [2*WIDTH-1:0] step_prod;

   assign is_mul = (mode == 5'd16);
   assign accept_target = is_mul ? BUSY : DONE;

   // One shift-add step: the multiplier drains out of prod_lo as the product fills in from the top.
   always_comb begin
      add_hi = {1'b0, prod_hi};
      if (prod_lo[0]) add_hi = {1'b0, prod_hi} + {1'b0, mcand};
      step_prod = {add_hi, prod_lo[WIDTH-1:1]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand    <= '0;
         prod_hi  <= '0;
         prod_lo  <= '0;
         step_cnt <= '0;
         out_hi   <= '0;
      end else if (accept && is_mul) begin
         mcand    <= A;
         prod_hi  <= '0;
         prod_lo  <= B;
         step_cnt <= '0;
      end else if (accept) begin
         out_hi <= '0;
      end else if (state == BUSY) begin
         prod_hi  <= step_prod[2*WIDTH-1:WIDTH];
         prod_lo  <= step_prod[WIDTH-1:0];
         step_cnt <= step_cnt + SHW'(1);
         if (step_cnt == LAST) out_hi <= step_prod[2*WIDTH-1:WIDTH];
      end
   end
`else
   assign is_mul = 1'b0;
   assign accept_target = DONE;
   assign out_hi = '0;
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state logic; DONE with out_ready behaves like IDLE so ops can run back-to-back.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept) next_state = accept_target;
`ifdef ALU_SEQ_MUL_EN
         BUSY: if (step_cnt == LAST) next_state = DONE;
`endif
         DONE: begin
            if (accept)         next_state = accept_target;
            else if (out_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Handshake outputs depend only on state and out_ready, never on in_valid.
   always_comb begin
      in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
      out_valid = (state == DONE);
   end

   // Single-cycle operations; opcodes with no entry here are flagged illegal.
   always_comb begin
      alu_res = '0;
      sum_ext = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_ill = 1'b0;
      case (mode)
         5'd0: begin
            sum_ext = {1'b0, A} + {1'b0, B};
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (A[MSB] == B[MSB]) && (alu_res[MSB] != A[MSB]);
         end
         5'd1: begin
            alu_res = A - B;
            alu_c   = (B > A);
            alu_v   = (A[MSB] != B[MSB]) && (alu_res[MSB] != A[MSB]);
         end
         5'd2:  alu_res = A;
         5'd3:  alu_res = B;
         5'd4:  alu_res = {{(WIDTH-1){1'b0}}, &A};
         5'd5:  alu_res = {{(WIDTH-1){1'b0}}, |A};
         5'd6:  alu_res = {{(WIDTH-1){1'b0}}, (A == '0)};
         5'd7:  alu_res = ~A;
         5'd8:  alu_res = A & B;
         5'd9:  alu_res = A | B;
         5'd10: alu_res = A ^ B;
         5'd11: alu_res = A << B[SHW-1:0];
         5'd12: alu_res = A >> B[SHW-1:0];
         5'd13: begin
            sum_ext = {1'b0, A} + {1'b0, ONE};
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = !A[MSB] && alu_res[MSB];
         end
         5'd14: begin
            alu_res = A - ONE;
            alu_c   = (A == '0);
            alu_v   = (A == MIN);
         end
         5'd15: begin
            alu_res = '0 - A;
            alu_c   = (A != '0);
            alu_v   = (A == MIN);
         end
`ifdef ALU_SEQ_MUL_EN
         5'd16: alu_ill = 1'b0;
`endif
         default: alu_ill = 1'b1;
      endcase
   end

   // Result and flag registers: written on a single-cycle accept or the final multiply step, held otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out      <= '0;
         flag_z   <= 1'b0;
         flag_n   <= 1'b0;
         flag_c   <= 1'b0;
         flag_v   <= 1'b0;
         flag_ill <= 1'b0;
      end else if (accept && !is_mul) begin
         out      <= alu_res;
         flag_z   <= (alu_res == '0);
         flag_n   <= alu_res[MSB];
         flag_c   <= alu_c;
         flag_v   <= alu_v;
         flag_ill <= alu_ill;
      end
`ifdef ALU_SEQ_MUL_EN
      else if ((state == BUSY) && (step_cnt == LAST)) begin
         out      <= step_prod[WIDTH-1:0];
         flag_z   <= (step_prod[WIDTH-1:0] == '0);
         flag_n   <= step_prod[MSB];
         flag_c   <= (step_prod[2*WIDTH-1:WIDTH] != '0);
         flag_v   <= 1'b0;
         flag_ill <= 1'b0;
      end
`endif
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): fixed vector table, hand-written
// multi-cycle sequences and randomized ops checked against an arithmetic model.
module tb_alu_seq;

   localparam int W = 8;
   localparam longint MOD = 64'd1 << W;
`ifdef ALU_SEQ_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [4:0]   mode;
   logic [W-1:0] A, B, out, out_hi;
   logic         flag_z, flag_n, flag_c, flag_v, flag_ill;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .A(A), .B(B),
      .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .out_hi(out_hi),
      .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v), .flag_ill(flag_ill)
   );

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic z, n, c, v, ill;
   } res_t;

   typedef struct {
      logic [4:0]   mode;
      logic [W-1:0] a, b, exp_out;
      logic         exp_z, exp_n, exp_c, exp_v, exp_ill;
   } vec_t;

   // Reference model: results from plain integer arithmetic on the opcode definitions.
   function automatic res_t refModel(int m, longint a, longint b);
      res_t r;
      longint full, sa, sb, sr;
      bit use_v;
      r = '0;
      full = 0;
      sr = 0;
      use_v = 1'b0;
      sa = (a >= MOD / 2) ? a - MOD : a;
      sb = (b >= MOD / 2) ? b - MOD : b;
      case (m)
         0:  begin full = a + b; r.c = (full >= MOD); sr = sa + sb; use_v = 1'b1; end
         1:  begin full = a - b; r.c = (b > a); sr = sa - sb; use_v = 1'b1; end
         2:  full = a;
         3:  full = b;
         4:  full = (a == MOD - 1) ? 1 : 0;
         5:  full = (a != 0) ? 1 : 0;
         6:  full = (a == 0) ? 1 : 0;
         7:  full = MOD - 1 - a;
         8:  full = a & b;
         9:  full = a | b;
         10: full = a ^ b;
         11: full = (a << (b % W)) % MOD;
         12: full = a >> (b % W);
         13: begin full = a + 1; r.c = (full >= MOD); sr = sa + 1; use_v = 1'b1; end
         14: begin full = a - 1; r.c = (a < 1); sr = sa - 1; use_v = 1'b1; end
         15: begin full = -a; r.c = (a > 0); sr = -sa; use_v = 1'b1; end
         16: begin
            if (MUL_EN) begin
               full = a * b;
               r.hi = W'(full / MOD);
               r.c = (full / MOD) != 0;
            end else begin
               r.ill = 1'b1;
            end
         end
         default: r.ill = 1'b1;
      endcase
      r.lo = W'(((full % MOD) + MOD) % MOD);
      r.v = use_v && ((sr > MOD / 2 - 1) || (sr < -(MOD / 2)));
      r.z = (r.lo == '0);
      r.n = r.lo[W-1];
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkResult(input string tag, input res_t e);
      checkOutput({tag, " out"}, out, e.lo);
      checkOutput({tag, " out_hi"}, out_hi, e.hi);
      checkOutput({tag, " flags zncvi"}, {flag_z, flag_n, flag_c, flag_v, flag_ill},
                  {e.z, e.n, e.c, e.v, e.ill});
   endtask

   // Issue one op with out_ready=1; returns the number of edges from the accept to out_valid.
   task automatic applyStimulus(input logic [4:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                                output int lat, output bit busy_ok);
      int n;
      @(negedge clk);
      mode = m; A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         fails++;
         tests++;
         $display("[TB] FAIL accept wait: in_ready stuck 0, expected 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0; A = ~a; B = ~b; mode = 5'd3;
      busy_ok = 1'b1;
      lat = 0;
      while (!out_valid && lat < 50) begin
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time exhausted, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   vec_t vecs[15];

   initial begin
      int lat;
      bit busy_ok;
      res_t e;
      logic [4:0] m;
      logic [W-1:0] a, b;

      vecs[0]  = '{5'd0,  8'hF0, 8'h20, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{5'd1,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{5'd15, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{5'd13, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{5'd8,  8'h3C, 8'h0F, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{5'd20, 8'h55, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[6]  = '{5'd11, 8'h81, 8'h0B, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{5'd12, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{5'd6,  8'h00, 8'h33, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{5'd15, 8'h80, 8'h00, 8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{5'd14, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{5'd4,  8'hFF, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{5'd7,  8'h5A, 8'h00, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{5'd0,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[14] = '{5'd31, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = '0; A = '0; B = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset out", out, 0);
      checkOutput("reset flags", {flag_z, flag_n, flag_c, flag_v, flag_ill}, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("post-reset in_ready", in_ready, 1);

      // Fixed vectors
      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].mode, vecs[i].a, vecs[i].b, lat, busy_ok);
         checkOutput($sformatf("vec%0d latency", i), lat, 0);
         checkOutput($sformatf("vec%0d out", i), out, vecs[i].exp_out);
         checkOutput($sformatf("vec%0d out_hi", i), out_hi, 0);
         checkOutput($sformatf("vec%0d flags zncvi", i), {flag_z, flag_n, flag_c, flag_v, flag_ill},
                     {vecs[i].exp_z, vecs[i].exp_n, vecs[i].exp_c, vecs[i].exp_v, vecs[i].exp_ill});
      end

`ifdef ALU_SEQ_MUL_EN
      applyStimulus(5'd16, 8'hFF, 8'hFF, lat, busy_ok);
      checkOutput("mul latency", lat, W);
      checkOutput("mul in_ready low while busy", busy_ok, 1);
      checkOutput("mul product", {out_hi, out}, 16'hFE01);
      checkOutput("mul flag_c", flag_c, 1);
`else
      applyStimulus(5'd16, 8'h12, 8'h34, lat, busy_ok);
      checkOutput("mul-off latency", lat, 0);
      checkOutput("mul-off out", {out_hi, out}, 0);
      checkOutput("mul-off flags zncvi", {flag_z, flag_n, flag_c, flag_v, flag_ill}, 5'b10001);
`endif

      // Back-pressure hold, then back-to-back accept on release
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      mode = 5'd8; A = 8'h3C; B = 8'h0F; in_valid = 1'b1; out_ready = 1'b0;
      #1;
      checkOutput("bp idle in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      mode = 5'd0; A = 8'h01; B = 8'h02;
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("bp hold%0d out", i), out, 8'h0C);
         checkOutput($sformatf("bp hold%0d valid/ready", i), {out_valid, in_ready}, 2'b10);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checkOutput("bp release in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("bp back-to-back out", out, 8'h03);
      checkOutput("bp back-to-back out_valid", out_valid, 1);

      // Throughput: one single-cycle op per clock with in_valid held high
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         m = 5'($urandom_range(0, 15));
         a = W'($urandom_range(0, 255));
         b = W'($urandom_range(0, 255));
         mode = m; A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
         #1;
         checkOutput($sformatf("tput%0d in_ready", i), in_ready, 1);
         @(posedge clk);
         #1;
         e = refModel(int'(m), longint'(a), longint'(b));
         checkOutput($sformatf("tput%0d out_valid", i), out_valid, 1);
         checkResult($sformatf("tput%0d", i), e);
         @(negedge clk);
      end
      in_valid = 1'b0;

      // Asynchronous reset in the middle of an operation
      @(negedge clk);
`ifdef ALU_SEQ_MUL_EN
      mode = 5'd16; A = 8'hFF; B = 8'hFF; out_ready = 1'b1;
`else
      mode = 5'd0; A = 8'hF0; B = 8'h20; out_ready = 1'b0;
`endif
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("async reset out_valid", out_valid, 0);
      checkOutput("async reset out", {out_hi, out}, 0);
      checkOutput("async reset flags", {flag_z, flag_n, flag_c, flag_v, flag_ill}, 0);
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("after reset in_ready", in_ready, 1);
      lat = 0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) lat++;
         @(posedge clk);
         #1;
      end
      checkOutput("aborted op never completes", lat, 0);
      applyStimulus(5'd13, 8'hFF, 8'h00, lat, busy_ok);
      checkOutput("inc after reset out", out, 8'h00);
      checkOutput("inc after reset z/c", {flag_z, flag_c}, 2'b11);

      // Randomized ops against the reference model, with occasional output stalls
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 9) == 0) m = 5'($urandom_range(16, 31));
         else                           m = 5'($urandom_range(0, 16));
         a = W'($urandom_range(0, 255));
         b = W'($urandom_range(0, 255));
         applyStimulus(m, a, b, lat, busy_ok);
         e = refModel(int'(m), longint'(a), longint'(b));
         checkOutput($sformatf("rnd%0d mode%0d latency", i, m), lat,
                     (MUL_EN && m == 5'd16) ? W : 0);
         checkOutput($sformatf("rnd%0d busy in_ready", i), busy_ok, 1);
         checkResult($sformatf("rnd%0d mode%0d", i, m), e);
         if ($urandom_range(0, 3) == 0) begin
            out_ready = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            checkOutput($sformatf("rnd%0d stall valid", i), out_valid, 1);
            checkResult($sformatf("rnd%0d stall", i), e);
            out_ready = 1'b1;
         end
      end

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
